// File: rtl/fsm2_seq.sv
// 3-bit self-correcting sequence generator: 6-state Johnson ring by default, or an
// 8-state Gray cycle when FSM2_GRAY_EN is defined. REVERSE selects traversal direction.
module fsm2_seq #(
    parameter int unsigned REVERSE = 0
) (
    input  logic clk,
    input  logic clr,
    output logic Q0,
    output logic Q1,
    output logic Q2
);

    logic [2:0] state_q;
    logic [2:0] state_d;

`ifdef FSM2_GRAY_EN
    localparam logic [2:0] StG0 = 3'b000;
    localparam logic [2:0] StG1 = 3'b001;
    localparam logic [2:0] StG2 = 3'b011;
    localparam logic [2:0] StG3 = 3'b010;
    localparam logic [2:0] StG4 = 3'b110;
    localparam logic [2:0] StG5 = 3'b111;
    localparam logic [2:0] StG6 = 3'b101;
    localparam logic [2:0] StG7 = 3'b100;

    always_comb begin
        state_d = StG0;
        if (REVERSE == 0) begin
            case (state_q)
                StG0:    state_d = StG1;
                StG1:    state_d = StG2;
                StG2:    state_d = StG3;
                StG3:    state_d = StG4;
                StG4:    state_d = StG5;
                StG5:    state_d = StG6;
                StG6:    state_d = StG7;
                StG7:    state_d = StG0;
                default: state_d = StG0;
            endcase
        end else begin
            case (state_q)
                StG0:    state_d = StG7;
                StG7:    state_d = StG6;
                StG6:    state_d = StG5;
                StG5:    state_d = StG4;
                StG4:    state_d = StG3;
                StG3:    state_d = StG2;
                StG2:    state_d = StG1;
                StG1:    state_d = StG0;
                default: state_d = StG0;
            endcase
        end
    end
`else
    localparam logic [2:0] StA = 3'b000;
    localparam logic [2:0] StB = 3'b001;
    localparam logic [2:0] StC = 3'b011;
    localparam logic [2:0] StD = 3'b111;
    localparam logic [2:0] StE = 3'b110;
    localparam logic [2:0] StF = 3'b100;

    // 010 and 101 fall into the default arm and recover to A.
    always_comb begin
        state_d = StA;
        if (REVERSE == 0) begin
            case (state_q)
                StA:     state_d = StB;
                StB:     state_d = StC;
                StC:     state_d = StD;
                StD:     state_d = StE;
                StE:     state_d = StF;
                StF:     state_d = StA;
                default: state_d = StA;
            endcase
        end else begin
            case (state_q)
                StA:     state_d = StF;
                StF:     state_d = StE;
                StE:     state_d = StD;
                StD:     state_d = StC;
                StC:     state_d = StB;
                StB:     state_d = StA;
                default: state_d = StA;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= 3'b000;
        end else begin
            state_q <= state_d;
        end
    end

    assign Q0 = state_q[0];
    assign Q1 = state_q[1];
    assign Q2 = state_q[2];

endmodule

// File: tb/tb_fsm2_seq.sv
// Directed bench for fsm2_seq: runs a forward and a reverse instance side by side.
// Build with FSM2_GRAY_EN defined to exercise the Gray-cycle variant.
module tb_fsm2_seq;

    logic clk;
    logic clr;
    logic f_q0, f_q1, f_q2;
    logic r_q0, r_q1, r_q2;
    logic [2:0] fwd_q;
    logic [2:0] rev_q;

    int total;
    int bad;

    assign fwd_q = {f_q2, f_q1, f_q0};
    assign rev_q = {r_q2, r_q1, r_q0};

    fsm2_seq #(.REVERSE(0)) fwd_dut (
        .clk (clk),
        .clr (clr),
        .Q0  (f_q0),
        .Q1  (f_q1),
        .Q2  (f_q2)
    );

    fsm2_seq #(.REVERSE(1)) rev_dut (
        .clk (clk),
        .clr (clr),
        .Q0  (r_q0),
        .Q1  (r_q1),
        .Q2  (r_q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

`ifdef FSM2_GRAY_EN
    logic [2:0] fwd_tbl [10] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                                 3'b101, 3'b100, 3'b000, 3'b001, 3'b011};
    logic [2:0] rev_tbl [10] = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010,
                                 3'b011, 3'b001, 3'b000, 3'b100, 3'b101};
    localparam logic [2:0] FwdAfter3 = 3'b010;
    localparam logic [2:0] RevAfter3 = 3'b111;
`else
    logic [2:0] fwd_tbl [10] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100,
                                 3'b000, 3'b001, 3'b011, 3'b111, 3'b110};
    logic [2:0] rev_tbl [10] = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001,
                                 3'b000, 3'b100, 3'b110, 3'b111, 3'b011};
    localparam logic [2:0] FwdAfter3 = 3'b111;
    localparam logic [2:0] RevAfter3 = 3'b111;
`endif

    initial begin
        logic [2:0] prev_f;
        logic [2:0] prev_r;
        total = 0;
        bad   = 0;
        clr   = 1'b1;

        // Assert reset before the first clock edge and hold it across several edges.
        #2 clr = 1'b0;
        #1;
        check_eq("reset_async_fwd", fwd_q, 3'b000);
        check_eq("reset_async_rev", rev_q, 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("reset_hold_fwd", fwd_q, 3'b000);
            check_eq("reset_hold_rev", rev_q, 3'b000);
        end

        // Release and run ten edges in both directions.
        clr = 1'b1;
        prev_f = 3'b000;
        prev_r = 3'b000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("run_fwd_%0d", i), fwd_q, fwd_tbl[i]);
            check_eq($sformatf("run_rev_%0d", i), rev_q, rev_tbl[i]);
            check_eq("onehot_fwd", 3'($countones(fwd_q ^ prev_f)), 3'd1);
            check_eq("onehot_rev", 3'($countones(rev_q ^ prev_r)), 3'd1);
            prev_f = fwd_q;
            prev_r = rev_q;
        end

        // Restart, step three edges, then clear asynchronously between edges.
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_pre_fwd", fwd_q, FwdAfter3);
        check_eq("mid_pre_rev", rev_q, RevAfter3);
        #1 clr = 1'b0;
        #1;
        check_eq("mid_async_fwd", fwd_q, 3'b000);
        check_eq("mid_async_rev", rev_q, 3'b000);
        #1 clr = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_restart_fwd", fwd_q, fwd_tbl[0]);
        check_eq("mid_restart_rev", rev_q, rev_tbl[0]);

`ifndef FSM2_GRAY_EN
        // Illegal states must recover to 000 in one edge, both directions.
        begin
            logic [2:0] bad_states [2] = '{3'b010, 3'b101};
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                force fwd_dut.state_q = bad_states[k];
                force rev_dut.state_q = bad_states[k];
                #1;
                release fwd_dut.state_q;
                release rev_dut.state_q;
                #1;
                check_eq("illegal_set_fwd", fwd_q, bad_states[k]);
                check_eq("illegal_set_rev", rev_q, bad_states[k]);
                @(posedge clk);
                #1;
                check_eq("illegal_rec_fwd", fwd_q, 3'b000);
                check_eq("illegal_rec_rev", rev_q, 3'b000);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm2_seq.md
Name: fsm2_seq

Overview:
- 3-bit registered sequence-generator state machine.
- Steps once per clock through a fixed 6-state Johnson (twisted-ring) code and presents the state directly on Q2..Q0.
- Used as a small phase/sequence source for downstream control logic.
- Self-correcting: any illegal state returns to the reset state on the next clock.

Parameters:
- REVERSE, 0, 0 = forward sequence; 1 = same cycle traversed in reverse order.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  asynchronous, active-low reset/clear; clr=0 forces the reset state immediately.
- Q0  output  1  state bit 0 (LSB), registered.
- Q1  output  1  state bit 1, registered.
- Q2  output  1  state bit 2 (MSB), registered.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (clr).
- State register S[2:0]. Outputs are the register itself: Q2=S[2], Q1=S[1], Q0=S[0]. No combinational path from input to output.
- Reset:
  - clr=0 sets S=000 asynchronously, independent of clk.
  - While clr=0, S holds 000.
  - Deassertion is sampled at rising edges. The first rising edge with clr=1 performs the first transition.
- Forward sequence (REVERSE=0), Q2Q1Q0: A=000 -> B=001 -> C=011 -> D=111 -> E=110 -> F=100 -> A.
  - Equivalent rule: S_next = {S[1], S[0], ~S[2]}.
- Reverse sequence (REVERSE=1): A=000 -> F=100 -> E=110 -> D=111 -> C=011 -> B=001 -> A.
  - Equivalent rule: S_next = {~S[0], S[2], S[1]}.
- Period is 6 clocks. Exactly one output bit changes per transition.
- Illegal states 010 and 101 (e.g. after upset or forced value): next rising edge goes to A=000, in both directions.
- Reset mid-sequence: clr=0 at any point returns to 000 without waiting for a clock edge. The sequence restarts from A after release.
- No enable and no hold. The FSM advances on every rising edge while clr=1.
- Decode state with a case statement over named states. Provide a default branch mapping to A.

Optional Feature:
- Macro: FSM2_GRAY_EN.
- When defined, the sequence becomes an 8-state 3-bit Gray cycle.
  - Forward: 000 -> 001 -> 011 -> 010 -> 110 -> 111 -> 101 -> 100 -> 000 (period 8).
  - REVERSE=1 traverses the same cycle backwards.
  - No illegal states exist in this mode.
  - Reset value remains 000.
- When not defined, the 6-state Johnson behaviour above applies, including illegal-state recovery.

Test Plan:
- Reset: clr=0 with clk running, then release clr=1 -> Q2Q1Q0 reads 000 throughout reset. The output becomes 000 asynchronously, before the next clk edge.
- Forward run (REVERSE=0): release reset, then 10 rising edges -> Q2Q1Q0 = 001, 011, 111, 110, 100, 000, 001, 011, 111, 110.
- Reverse run (REVERSE=1): release reset, then 7 edges -> 100, 110, 111, 011, 001, 000, 100.
- Mid-run reset: after 3 edges (state 111), pulse clr=0 between edges -> Q immediately 000. After release, the next edge gives 001.
- Illegal recovery: force S=010, then one edge -> 000. Force S=101, then one edge -> 000 (both REVERSE values).
- With FSM2_GRAY_EN defined, REVERSE=0: release reset, then 9 edges -> 001, 011, 010, 110, 111, 101, 100, 000, 001. Exactly one bit toggles per edge.
